filter_load_ctrl: RTL and testbench
===================================

// Module: filter_load_ctrl
// PURPOSE
//  Sequences the 16x8 filter buffer for the convolution datapath.
//  On start, fetches filt_len taps from memory in 4-word groups and issues load/write_address to the buffer.
//  Then sweeps read index 0..filt_len-1 for n_passes passes under a valid/ready handshake with the MAC datapath.
//  Signals done when complete.
// PARAMETERS
//  DEPTH       16  filter buffer entries; index/write_address width = $clog2(DEPTH)
//  GROUP       4   words written per buffer load (buffer's 4-wide input)
//  AW          8   memory address width
// PORTS
//  clk            in   1   system clock, rising edge
//  rst            in   1   asynchronous, active-low reset
//  start          in   1   begin a job; sampled only in IDLE
//  base_addr      in   AW  memory address of tap 0
//  filt_len       in   5   taps to use, 1..16; 0 = empty job
//  n_passes       in   8   read sweeps over the taps; 0 treated as 1
//  mem_req        out  1   memory read request for a 4-word group
//  mem_addr       out  AW  group address = base_addr + wptr (mod 2^AW)
//  mem_valid      in   1   group data present on buffer inputs this cycle
//  load           out  1   buffer write enable
//  write_address  out  4   buffer group base (0,4,8,12)
//  index          out  4   buffer read index
//  idx_valid      out  1   index is meaningful for the datapath
//  idx_ready      in   1   datapath consumes index this cycle
//  busy           out  1   high in every state except IDLE
//  done           out  1   one-cycle completion pulse
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all outputs 0; internal wptr, rptr, pass, and latched fields 0.
//   Buffer contents are not touched. Reset mid-job aborts with no done.
//  IDLE: start=1 latches base_addr, filt_len, n_passes; wptr=0.
//   filt_len=0 goes to DONE; otherwise goes to FETCH.
//  FETCH: mem_req=1, mem_addr=base_addr+wptr; held stable until mem_valid.
//   In the mem_valid cycle: load=1 (combinational), write_address=wptr; wptr+=4 at the edge.
//   After group ceil(filt_len/4)-1 goes to SWEEP with rptr=0, pass=0; otherwise stays in FETCH.
//   mem_valid outside FETCH is ignored; load stays 0.
//  SWEEP: idx_valid=1, index=rptr. The index advances only on idx_valid&idx_ready.
//   Holding idx_ready=0 stalls index stable indefinitely.
//   Accept with rptr==filt_len-1: rptr=0, pass+=1.
//   If pass==max(n_passes,1)-1, go to DONE instead.
//  DONE: done=1 for exactly one cycle; busy=1; next state IDLE.
//  start while busy: ignored, not queued. start in the same cycle DONE->IDLE: ignored.
//   Earliest restart is the cycle after done.
//  Latency: start -> first mem_req is 1 cycle. Last accept -> done is 1 cycle.
//  Partial last group: full 4 words are loaded. Taps >= filt_len are never indexed.
//  Arithmetic: wptr 4-bit, max 12, never wraps. pass 8-bit compare. mem_addr wraps mod 2^AW.
// STRUCTURE
//  Package filter_ctrl_pkg holds:
//   - enum state_t {IDLE, FETCH, SWEEP, DONE}
//   - localparams DEPTH, GROUP, IDX_W
//  Sub-module filter_sweep_counter holds rptr and pass.
//   Inputs: clear, adv, filt_len, n_passes. Outputs: index, last.
//  Top module holds the FSM, wptr, and the latched job fields.
// TESTING
//  - filt_len=9, base=0x20, n_passes=1, mem_valid 2 cycles after each req:
//     mem_addr 0x20, 0x24, 0x28; three load pulses with write_address 0, 4, 8.
//     Then index 0..8 and one done pulse.
//  - filt_len=4, n_passes=3, idx_ready=1 always:
//     index sequence 0,1,2,3 repeated 3 times (12 accepts). done 1 cycle after the 12th accept.
//  - SWEEP with idx_ready toggling 1,0,0,1: index holds across the stalled cycles.
//     No skipped or duplicated index.
//  - filt_len=0: done 1 cycle after start. No mem_req, no load, no idx_valid.
//  - rst low mid-FETCH with mem_req=1: all outputs 0 asynchronously.
//     After release, start is accepted normally.
//  - start pulsed during SWEEP and in the done cycle: no effect.
//     filt_len=16, base=0xFE: mem_addr 0xFE, 0x02, 0x06, 0x0A (wrap).

Source files
------------

// File: rtl/filter_ctrl_pkg.sv
// rtl/filter_ctrl_pkg.sv - shared types and sizes for the filter buffer load controller
package filter_ctrl_pkg;

    localparam int DEPTH = 16;
    localparam int GROUP = 4;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/filter_sweep_counter.sv
// rtl/filter_sweep_counter.sv - read index and pass counters for the tap sweep
module filter_sweep_counter
    import filter_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_adv,
    input  logic [4:0]       i_filt_len,
    input  logic [7:0]       i_n_passes,
    output logic [IDX_W-1:0] o_index,
    output logic             o_last
);

    logic [IDX_W-1:0] r_rptr;
    logic [7:0]       r_pass;
    logic [7:0]       w_passes_eff;
    logic             w_last_tap;
    logic             w_last_pass;

    // A zero pass count still sweeps the taps once.
    assign w_passes_eff = (i_n_passes == 8'd0) ? 8'd1 : i_n_passes;
    assign w_last_tap   = ({1'b0, r_rptr} == (i_filt_len - 5'd1));
    assign w_last_pass  = (r_pass == (w_passes_eff - 8'd1));

    assign o_index = r_rptr;
    assign o_last  = w_last_tap && w_last_pass;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rptr <= '0;
            r_pass <= '0;
        end else if (i_clear) begin
            r_rptr <= '0;
            r_pass <= '0;
        end else if (i_adv) begin
            if (w_last_tap) begin
                r_rptr <= '0;
                r_pass <= r_pass + 8'd1;
            end else begin
                r_rptr <= r_rptr + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/filter_load_ctrl.sv
// rtl/filter_load_ctrl.sv - fetches filter taps into the 16x8 buffer, then sweeps read indices for the MAC
module filter_load_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [AW-1:0]    i_base_addr,
    input  logic [4:0]       i_filt_len,
    input  logic [7:0]       i_n_passes,
    output logic             o_mem_req,
    output logic [AW-1:0]    o_mem_addr,
    input  logic             i_mem_valid,
    output logic             o_load,
    output logic [IDX_W-1:0] o_write_address,
    output logic [IDX_W-1:0] o_index,
    output logic             o_idx_valid,
    input  logic             i_idx_ready,
    output logic             o_busy,
    output logic             o_done
);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_wptr;
    logic [AW-1:0]    r_base;
    logic [4:0]       r_len;
    logic [7:0]       r_passes;

    logic             w_fetch;
    logic             w_sweep;
    logic             w_load;
    logic             w_adv;
    logic             w_last;
    logic             w_last_group;
    logic [4:0]       w_len_m1;
    logic [IDX_W-1:0] w_index;

    assign w_fetch  = (r_state == FETCH);
    assign w_sweep  = (r_state == SWEEP);
    assign w_load   = w_fetch && i_mem_valid;
    assign w_adv    = w_sweep && i_idx_ready;
    assign w_len_m1 = r_len - 5'd1;

    // The group holding tap filt_len-1 is the final one to fetch.
    assign w_last_group = (r_wptr[IDX_W-1:2] == w_len_m1[IDX_W-1:2]);

    filter_sweep_counter u_sweep (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (!w_sweep),
        .i_adv      (w_adv),
        .i_filt_len (r_len),
        .i_n_passes (r_passes),
        .o_index    (w_index),
        .o_last     (w_last)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (i_start) w_next = (i_filt_len == 5'd0) ? DONE : FETCH;
            FETCH: if (i_mem_valid && w_last_group) w_next = SWEEP;
            SWEEP: if (w_adv && w_last) w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state  <= IDLE;
            r_wptr   <= '0;
            r_base   <= '0;
            r_len    <= '0;
            r_passes <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && i_start) begin
                r_base   <= i_base_addr;
                r_len    <= i_filt_len;
                r_passes <= i_n_passes;
                r_wptr   <= '0;
            end else if (w_load && !w_last_group) begin
                r_wptr <= r_wptr + IDX_W'(GROUP);
            end
        end
    end

    // Address and indices are gated so idle outputs read as zero.
    assign o_mem_req       = w_fetch;
    assign o_mem_addr      = w_fetch ? (r_base + AW'(r_wptr)) : '0;
    assign o_load          = w_load;
    assign o_write_address = w_load ? r_wptr : '0;
    assign o_idx_valid     = w_sweep;
    assign o_index         = w_sweep ? w_index : '0;
    assign o_busy          = (r_state != IDLE);
    assign o_done          = (r_state == DONE);

endmodule

// File: tb/tb_filter_load_ctrl.sv
// tb/tb_filter_load_ctrl.sv - directed self-checking bench for filter_load_ctrl
module tb_filter_load_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [4:0] filt_len;
    logic [7:0] n_passes;
    logic       mem_valid;
    logic       idx_ready;
    logic       o_mem_req;
    logic [7:0] o_mem_addr;
    logic       o_load;
    logic [3:0] o_write_address;
    logic [3:0] o_index;
    logic       o_idx_valid;
    logic       o_busy;
    logic       o_done;

    always #5 clk = ~clk;

    filter_load_ctrl #(.AW(8)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_base_addr     (base_addr),
        .i_filt_len      (filt_len),
        .i_n_passes      (n_passes),
        .o_mem_req       (o_mem_req),
        .o_mem_addr      (o_mem_addr),
        .i_mem_valid     (mem_valid),
        .o_load          (o_load),
        .o_write_address (o_write_address),
        .o_index         (o_index),
        .o_idx_valid     (o_idx_valid),
        .i_idx_ready     (idx_ready),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    int q_addr[$];
    int q_wa[$];
    int q_idx[$];
    int done_k, n_done, n_req, n_load, n_valid, last_acc;
    int viol_stall, viol_addr, post_busy;
    bit timed_out;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outs_packed();
        return {o_mem_req, o_mem_addr, o_load, o_write_address,
                o_index, o_idx_valid, o_busy, o_done};
    endfunction

    // Memory answers 2 cycles after each request; mem_valid is held high
    // whenever no request is pending to show it is ignored outside FETCH.
    task automatic run_job(input logic [7:0] b, input logic [4:0] l,
                           input logic [7:0] np, input bit toggle, input bit inject);
        bit         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int         wait_cnt = 0;
        int         sw = 0;
        int         k = 0;
        int         post = 0;
        bit         seen = 0;
        bit         prev_stall = 0;
        bit         prev_hold = 0;
        logic [3:0] prev_idx = '0;
        logic [7:0] prev_addr = '0;
        q_addr.delete(); q_wa.delete(); q_idx.delete();
        done_k = -1; n_done = 0; n_req = 0; n_load = 0; n_valid = 0; last_acc = -1;
        viol_stall = 0; viol_addr = 0; post_busy = 0;
        @(negedge clk);
        start = 1'b1; base_addr = b; filt_len = l; n_passes = np;
        mem_valid = 1'b0; idx_ready = 1'b0;
        while (k < 400 && post < 3) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (o_mem_req) begin
                if (wait_cnt == 2) begin mem_valid = 1'b1; wait_cnt = 0; end
                else begin mem_valid = 1'b0; wait_cnt++; end
            end else begin
                mem_valid = 1'b1;
                wait_cnt  = 0;
            end
            if (o_idx_valid) begin
                idx_ready = toggle ? pat[sw % 4] : 1'b1;
                sw++;
                if (inject && sw == 3) start = 1'b1;
            end else begin
                idx_ready = 1'b0;
            end
            if (o_done && inject) start = 1'b1;
            #1;
            if (o_mem_req) n_req++;
            if (o_load) begin
                n_load++;
                q_addr.push_back(int'(o_mem_addr));
                q_wa.push_back(int'(o_write_address));
            end
            if (prev_hold && o_mem_req && o_mem_addr != prev_addr) viol_addr++;
            prev_hold = o_mem_req && !o_load;
            prev_addr = o_mem_addr;
            if (o_idx_valid) n_valid++;
            if (prev_stall && o_index != prev_idx) viol_stall++;
            prev_stall = o_idx_valid && !idx_ready;
            prev_idx   = o_index;
            if (o_idx_valid && idx_ready) begin
                q_idx.push_back(int'(o_index));
                last_acc = k;
            end
            if (seen) begin
                post++;
                if (o_busy) post_busy++;
            end
            if (o_done) begin
                n_done++;
                done_k = k;
                seen   = 1'b1;
            end
        end
        start     = 1'b0;
        timed_out = !seen;
        check("job_timeout", int'(timed_out), 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; base_addr = '0; filt_len = '0; n_passes = '0;
        mem_valid = 1'b0; idx_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", outs_packed(), 0);
        rst = 1'b1;

        // 9 taps from 0x20, one pass
        run_job(8'h20, 5'd9, 8'd1, 1'b0, 1'b0);
        check("t1_loads", n_load, 3);
        for (int i = 0; i < 3; i++) begin
            check("t1_addr", (i < q_addr.size()) ? q_addr[i] : -1, 8'h20 + 4 * i);
            check("t1_wa", (i < q_wa.size()) ? q_wa[i] : -1, 4 * i);
        end
        check("t1_nidx", q_idx.size(), 9);
        for (int i = 0; i < 9; i++)
            check("t1_idx", (i < q_idx.size()) ? q_idx[i] : -1, i);
        check("t1_done_cnt", n_done, 1);
        check("t1_done_cycle", done_k, 19);
        check("t1_addr_stable", viol_addr, 0);

        // 4 taps, 3 passes, always ready
        run_job(8'h40, 5'd4, 8'd3, 1'b0, 1'b0);
        check("t2_loads", n_load, 1);
        check("t2_nidx", q_idx.size(), 12);
        for (int i = 0; i < 12; i++)
            check("t2_idx", (i < q_idx.size()) ? q_idx[i] : -1, i % 4);
        check("t2_done_after_last", done_k - last_acc, 1);
        check("t2_done_cycle", done_k, 16);

        // ready toggling 1,0,0,1 over 5 taps
        run_job(8'h00, 5'd5, 8'd1, 1'b1, 1'b0);
        check("t3_nidx", q_idx.size(), 5);
        for (int i = 0; i < 5; i++)
            check("t3_idx", (i < q_idx.size()) ? q_idx[i] : -1, i);
        check("t3_stall_hold", viol_stall, 0);
        check("t3_valid_cycles", n_valid, 9);
        check("t3_done_cycle", done_k, 16);

        // empty job
        run_job(8'h33, 5'd0, 8'd4, 1'b0, 1'b0);
        check("t4_done_cycle", done_k, 1);
        check("t4_req", n_req, 0);
        check("t4_load", n_load, 0);
        check("t4_valid", n_valid, 0);

        // zero passes behaves as one
        run_job(8'h50, 5'd2, 8'd0, 1'b0, 1'b0);
        check("t5_nidx", q_idx.size(), 2);
        check("t5_done_cycle", done_k, 6);

        // asynchronous reset in the middle of FETCH
        @(negedge clk);
        start = 1'b1; base_addr = 8'h10; filt_len = 5'd8; n_passes = 8'd1; mem_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        check("t6_req_before_rst", int'(o_mem_req), 1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_zero", outs_packed(), 0);
        @(negedge clk);
        rst = 1'b1;
        run_job(8'h10, 5'd8, 8'd2, 1'b0, 1'b0);
        check("t6_loads", n_load, 2);
        check("t6_addr1", (q_addr.size() > 1) ? q_addr[1] : -1, 8'h14);
        check("t6_nidx", q_idx.size(), 16);
        check("t6_done_cycle", done_k, 23);

        // 16 taps wrapping the address, start pulsed in SWEEP and DONE
        run_job(8'hFE, 5'd16, 8'd1, 1'b0, 1'b1);
        check("t7_loads", n_load, 4);
        for (int i = 0; i < 4; i++) begin
            check("t7_addr", (i < q_addr.size()) ? q_addr[i] : -1, (8'hFE + 4 * i) % 256);
            check("t7_wa", (i < q_wa.size()) ? q_wa[i] : -1, 4 * i);
        end
        check("t7_nidx", q_idx.size(), 16);
        check("t7_last_idx", (q_idx.size() > 15) ? q_idx[15] : -1, 15);
        check("t7_done_cnt", n_done, 1);
        check("t7_done_cycle", done_k, 29);
        check("t7_idle_after", post_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
